// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector onto a gate, samples its output, counts mismatches.
// Optional first-failure capture ports are enabled with `define GATE_SWEEP_FAIL_CAPTURE_EN.
module gate_sweep_ctrl #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected_tt,
    output logic [N_IN-1:0]      gate_in,
    input  logic                 gate_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_valid,
`endif
    output logic [ERR_W-1:0]     err_count
);

    localparam int NVEC  = 2**N_IN;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [N_IN-1:0]  LAST_IDX    = N_IN'(NVEC - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   index, index_nxt;
    logic [SET_W-1:0]  settle, settle_nxt;
    logic [NVEC-1:0]   tt_lat, tt_nxt;
    logic [ERR_W-1:0]  err_nxt;
    logic              pass_nxt;
    logic              mismatch;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic [N_IN-1:0]   ff_vec_nxt;
    logic              ff_valid_nxt;
`endif

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    assign mismatch = (gate_y != tt_lat[index]);

    always_comb begin
        state_nxt  = state;
        index_nxt  = index;
        settle_nxt = settle;
        tt_nxt     = tt_lat;
        err_nxt    = err_count;
        pass_nxt   = pass;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        ff_vec_nxt   = first_fail_vec;
        ff_valid_nxt = first_fail_valid;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    tt_nxt     = expected_tt;
                    index_nxt  = '0;
                    err_nxt    = '0;
                    settle_nxt = '0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                    ff_vec_nxt   = '0;
                    ff_valid_nxt = 1'b0;
`endif
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    settle_nxt = settle + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_nxt = sat_inc(err_count);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                    if (!first_fail_valid) begin
                        ff_vec_nxt   = index;
                        ff_valid_nxt = 1'b1;
                    end
`endif
                end
                // pass is taken from the post-increment count so the last vector is included
                if (index == LAST_IDX) begin
                    pass_nxt  = (err_nxt == '0);
                    state_nxt = FIN;
                end else begin
                    index_nxt  = index + 1'b1;
                    settle_nxt = '0;
                    state_nxt  = DRIVE;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            settle    <= '0;
            tt_lat    <= '0;
            err_count <= '0;
            pass      <= 1'b0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            settle    <= settle_nxt;
            tt_lat    <= tt_nxt;
            err_count <= err_nxt;
            pass      <= pass_nxt;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
            first_fail_vec   <= ff_vec_nxt;
            first_fail_valid <= ff_valid_nxt;
`endif
        end
    end

    assign busy    = (state == DRIVE) || (state == CHECK);
    assign gate_in = busy ? index : '0;
    assign done    = (state == FIN);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized scoreboard bench for gate_sweep_ctrl; a second instance with ERR_W=1 covers saturation.
module tb_gate_sweep_ctrl;

    localparam int N_IN = 2;
    localparam int S    = 2;
    localparam int NV   = 2**N_IN;
    localparam int SW   = NV * (S + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, start;
    logic [NV-1:0]   expected_tt;
    logic [NV-1:0]   gate_tt;
    logic [N_IN-1:0] gate_in, gate_in1;
    logic            gate_y, gate_y1;
    logic            busy, done, pass, busy1, done1, pass1;
    logic [3:0]      err_count;
    logic [0:0]      err_count1;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic [N_IN-1:0] ffv, ffv1;
    logic            ffval, ffval1;
`endif

    assign gate_y  = gate_tt[gate_in];
    assign gate_y1 = gate_tt[gate_in1];

    gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(S), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected_tt(expected_tt),
        .gate_in(gate_in), .gate_y(gate_y), .busy(busy), .done(done), .pass(pass),
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        .first_fail_vec(ffv), .first_fail_valid(ffval),
`endif
        .err_count(err_count)
    );

    gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(S), .ERR_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected_tt(expected_tt),
        .gate_in(gate_in1), .gate_y(gate_y1), .busy(busy1), .done(done1), .pass(pass1),
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        .first_fail_vec(ffv1), .first_fail_valid(ffval1),
`endif
        .err_count(err_count1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int err;
        int err1;
        bit pass;
        int ffv;
        bit ffvalid;
    } exp_t;

    exp_t sb[$];
    int   done_cycles[$];

    // Reference: count the table positions where the gate disagrees with the expectation.
    function automatic exp_t model_sweep(input logic [NV-1:0] gt, input logic [NV-1:0] et);
        exp_t e;
        int cnt = 0;
        e.ffv = 0;
        e.ffvalid = 0;
        for (int i = 0; i < NV; i++) begin
            if (gt[i] != et[i]) begin
                if (!e.ffvalid) e.ffv = i;
                e.ffvalid = 1;
                cnt++;
            end
        end
        e.err  = (cnt > 15) ? 15 : cnt;
        e.err1 = (cnt > 1) ? 1 : cnt;
        e.pass = (cnt == 0);
        return e;
    endfunction

    // Timing model: a sweep accepted at edge acc shows vectors for SW cycles, then one done cycle,
    // then one idle cycle before another start can be taken.
    int cyc = 0;
    int acc = 0;
    bit active = 0;
    bit pass_m = 0;
    bit pend_pass = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                active = 0;
                pass_m = 0;
                sb.delete();
            end else begin
                if (active && (cyc - acc == SW)) pass_m = pend_pass;
                if (start && (!active || (cyc - acc >= SW + 2))) begin
                    exp_t e;
                    e = model_sweep(gate_tt, expected_tt);
                    acc = cyc;
                    active = 1;
                    pend_pass = e.pass;
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor
    initial begin
        int k;
        logic [31:0] egi;
        bit eb, ed;
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            k = cyc - acc;
            egi = 0; eb = 0; ed = 0;
            if (active && k >= 0 && k < SW) begin
                egi = k / (S + 1);
                eb = 1;
            end else if (active && k == SW) begin
                ed = 1;
            end
            chk("gate_in", gate_in, egi);
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("pass", pass, pass_m);
            if (done === 1'b1) begin
                done_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("done_without_sweep", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err_count", err_count, e.err);
                    chk("err_count_sat1", err_count1, e.err1);
                    chk("done_sat1", done1, 1);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                    chk("first_fail_valid", ffval, e.ffvalid);
                    if (e.ffvalid) chk("first_fail_vec", ffv, e.ffv);
`endif
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active && (cyc - acc < SW + 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run(input logic [NV-1:0] gt, input logic [NV-1:0] et);
        @(negedge clk);
        gate_tt = gt;
        expected_tt = et;
        pulse_start();
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        expected_tt = '0;
        gate_tt = '0;
        repeat (3) @(negedge clk);
        chk("reset_err_count", err_count, 0);
        chk("reset_err_count1", err_count1, 0);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        chk("reset_ffvalid", ffval, 0);
        chk("reset_ffvec", ffv, 0);
`endif
        rst_n = 1'b1;

        // Directed: OR gate correct, AND table against OR, stuck-at-0 output
        run(4'b1110, 4'b1110);
        run(4'b1110, 4'b1000);
        run(4'b0000, 4'b1110);

        // Reset while vector 2 is being driven
        @(negedge clk);
        gate_tt = 4'b1110;
        expected_tt = 4'b1110;
        pulse_start();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_err_count", err_count, 0);
        chk("abort_busy", busy, 0);
        run(4'b1110, 4'b1110);

        // Mid-sweep start and table change are ignored; start in the done cycle is ignored too
        @(negedge clk);
        gate_tt = 4'b1110;
        expected_tt = 4'b1110;
        pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        expected_tt = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        while (cyc - acc < SW) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held high: back-to-back sweeps separated by the done and idle cycles
        done_cycles.delete();
        @(negedge clk);
        gate_tt = 4'b0110;
        expected_tt = 4'b1110;
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("held_sweep_count", done_cycles.size() >= 2, 1);
        for (int i = 1; i < done_cycles.size(); i++)
            chk("done_spacing", done_cycles[i] - done_cycles[i-1], SW + 2);

        // Randomized sweeps with random start pulses and table churn during the sweep
        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            gate_tt = NV'($urandom);
            expected_tt = NV'($urandom);
            pulse_start();
            for (int c = 0; c < SW; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 3) == 0);
                expected_tt = NV'($urandom);
            end
            start = 1'b0;
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
